// File: rtl/mgt_01_context_unit_if.sv
// rtl/mgt_01_context_unit_if.sv - memory request/response bus of the context unit
interface mgt_01_context_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mgt_01_context_unit.sv
// rtl/mgt_01_context_unit.sv - register-file context save/restore engine over a
// single-outstanding memory request bus
module mgt_01_context_unit #(
  parameter int NREG = 31,
  parameter int XLEN = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       save_req_i,
  input  logic                       restore_req_i,
  input  logic [XLEN-1:0]            base_addr_i,
  input  logic [NREG:0][XLEN-1:0]    ireg_file_i,
  output logic [NREG:0][XLEN-1:0]    ireg_file_o,
  output logic                       load_all_o,
  output logic                       busy_o,
  output logic                       done_o,
  mgt_01_context_unit_if.master      mem
);

  localparam int IW = $clog2(NREG + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SAVE    = 3'd1;
  localparam logic [2:0] S_LD_REQ  = 3'd2;
  localparam logic [2:0] S_LD_WAIT = 3'd3;
  localparam logic [2:0] S_COMMIT  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [XLEN-1:0]          base_q, base_d;
  logic [NREG:0][XLEN-1:0]  buf_q, buf_d;
  logic                     done_q, done_d;

  logic                     last_idx;
  logic [IW-1:0]            idx_m1;
  logic [XLEN-1:0]          addr_off;

  assign last_idx = (idx_q == IW'(NREG));
  assign idx_m1   = idx_q - IW'(1);
  // Offset wraps naturally in XLEN bits, so base+offset is modulo 2^XLEN.
  assign addr_off = XLEN'(idx_m1) << 2;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (save_req_i) begin
          buf_d    = ireg_file_i;
          buf_d[0] = '0;
          base_d   = base_addr_i;
          idx_d    = IW'(1);
          state_d  = S_SAVE;
        end else if (restore_req_i) begin
          base_d  = base_addr_i;
          idx_d   = IW'(1);
          state_d = S_LD_REQ;
        end
      end
      S_SAVE: begin
        if (mem.mem_gnt_i) begin
          if (last_idx) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_LD_REQ: begin
        if (mem.mem_gnt_i) begin
          state_d = S_LD_WAIT;
        end
      end
      S_LD_WAIT: begin
        if (mem.mem_rvalid_i) begin
          buf_d[idx_q] = mem.mem_rdata_i;
          if (last_idx) begin
            state_d = S_COMMIT;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_LD_REQ;
          end
        end
      end
      S_COMMIT: begin
        idx_d   = '0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    ireg_file_o    = buf_q;
    ireg_file_o[0] = '0;
  end

  assign busy_o     = (state_q != S_IDLE);
  assign load_all_o = (state_q == S_COMMIT);
  assign done_o     = done_q;

  assign mem.mem_req_o   = (state_q == S_SAVE) || (state_q == S_LD_REQ);
  assign mem.mem_we_o    = (state_q == S_SAVE);
  assign mem.mem_addr_o  = mem.mem_req_o ? (base_q + addr_off) : '0;
  assign mem.mem_wdata_o = (state_q == S_SAVE) ? buf_q[idx_q] : '0;

endmodule

// File: tb/tb_mgt_01_context_unit.sv
// tb/tb_mgt_01_context_unit.sv - scoreboard bench for the context save/restore engine
module tb_mgt_01_context_unit;
  localparam int NREG = 31;
  localparam int XLEN = 32;

  typedef logic [NREG:0][XLEN-1:0] img_t;
  typedef struct {
    int              kind;   // 0 memory access, 1 commit, 2 done
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    img_t            img;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            save_req_i = 1'b0;
  logic            restore_req_i = 1'b0;
  logic [XLEN-1:0] base_addr_i = '0;
  img_t            ireg_file_i = '0;
  img_t            ireg_file_o;
  logic            load_all_o, busy_o, done_o;

  mgt_01_context_unit_if #(.XLEN(XLEN)) mem_if ();

  mgt_01_context_unit #(.NREG(NREG), .XLEN(XLEN)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .save_req_i   (save_req_i),
    .restore_req_i(restore_req_i),
    .base_addr_i  (base_addr_i),
    .ireg_file_i  (ireg_file_i),
    .ireg_file_o  (ireg_file_o),
    .load_all_o   (load_all_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mem          (mem_if)
  );

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];
  int  hs_cnt = 0;
  int  hold_cnt = 0;
  logic [XLEN-1:0] hold_addr = 32'h0000_0003;

  // memory slave controls
  int              gnt_mode = 0;   // 0 always grant, 1 random, 2 stall on stall_addr
  int              rv_delay = 2;   // 0 selects a random delay per read
  bit              noise = 1'b0;
  logic [XLEN-1:0] salt = '0;
  logic [XLEN-1:0] stall_addr = '0;
  int              stall_left = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input img_t act, input img_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i <= NREG; i++) begin
        if (act[i] !== exp[i]) begin
          $display("FAIL %s: entry %0d got %h expected %h", name, i, act[i], exp[i]);
          break;
        end
      end
    end
  endtask

  task automatic take(input int kind, input string what, output bit ok, output ev_t e);
    checks++;
    ok = 1'b0;
    e  = '{kind: -1, we: 1'b0, addr: '0, data: '0, img: '0};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event with empty scoreboard", what);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL %s: got event kind %0d expected kind %0d", what, kind, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin : monitor
    ev_t e;
    bit  ok;
    if (!rst_i) begin
      checks++;
      if (mem_if.mem_req_o && (!busy_o || load_all_o)) begin
        errors++;
        $display("FAIL req_idle_commit: got mem_req_o=1 busy_o=%b load_all_o=%b expected mem_req_o=0", busy_o, load_all_o);
      end
      if (mem_if.mem_req_o && mem_if.mem_addr_o == hold_addr) hold_cnt++;
      if (mem_if.mem_req_o && mem_if.mem_gnt_i) begin
        hs_cnt++;
        take(0, "mem_access", ok, e);
        if (ok) begin
          chk("mem_we", {31'b0, mem_if.mem_we_o}, {31'b0, e.we});
          chk("mem_addr", mem_if.mem_addr_o, e.addr);
          chk("mem_wdata", mem_if.mem_wdata_o, e.data);
        end
      end
      if (load_all_o) begin
        take(1, "commit", ok, e);
        if (ok) chk_img("commit_image", ireg_file_o, e.img);
      end
      if (done_o) begin
        take(2, "done", ok, e);
        if (ok) chk_img("done_image", ireg_file_o, e.img);
      end
    end
  end

  // memory slave
  initial begin : mem_slave
    bit              rd_pend;
    int              rd_cnt;
    logic [XLEN-1:0] rd_addr;
    rd_pend = 1'b0;
    rd_cnt  = 0;
    rd_addr = '0;
    mem_if.mem_gnt_i    = 1'b1;
    mem_if.mem_rvalid_i = 1'b0;
    mem_if.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_i) rd_pend = 1'b0;
      else if (mem_if.mem_req_o && !mem_if.mem_we_o && mem_if.mem_gnt_i) begin
        rd_pend = 1'b1;
        rd_addr = mem_if.mem_addr_o;
        rd_cnt  = (rv_delay != 0) ? rv_delay : int'($urandom_range(1, 4));
      end
      @(posedge clk);
      #1;
      if (rst_i) rd_pend = 1'b0;
      mem_if.mem_rvalid_i = 1'b0;
      mem_if.mem_rdata_i  = $urandom;
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_if.mem_rvalid_i = 1'b1;
          mem_if.mem_rdata_i  = ~rd_addr ^ salt;
          rd_pend = 1'b0;
        end
      end else if (noise && $urandom_range(0, 3) == 0) begin
        mem_if.mem_rvalid_i = 1'b1;
      end
      case (gnt_mode)
        0: mem_if.mem_gnt_i = 1'b1;
        1: mem_if.mem_gnt_i = ($urandom_range(0, 2) != 0);
        default: begin
          if (mem_if.mem_req_o && mem_if.mem_addr_o == stall_addr && stall_left > 0) begin
            mem_if.mem_gnt_i = 1'b0;
            stall_left--;
          end else begin
            mem_if.mem_gnt_i = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic push_save(input logic [XLEN-1:0] base, input img_t snap);
    ev_t e;
    for (int i = 1; i <= NREG; i++) begin
      e = '{kind: 0, we: 1'b1, addr: base + XLEN'(4 * (i - 1)), data: snap[i], img: '0};
      exp_q.push_back(e);
    end
    e = '{kind: 2, we: 1'b0, addr: '0, data: '0, img: snap};
    e.img[0] = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_restore(input logic [XLEN-1:0] base, input logic [XLEN-1:0] s);
    ev_t  e;
    img_t img;
    img = '0;
    for (int i = 1; i <= NREG; i++) begin
      e = '{kind: 0, we: 1'b0, addr: base + XLEN'(4 * (i - 1)), data: '0, img: '0};
      exp_q.push_back(e);
      img[i] = ~(base + XLEN'(4 * (i - 1))) ^ s;
    end
    e = '{kind: 1, we: 1'b0, addr: '0, data: '0, img: img};
    exp_q.push_back(e);
    e.kind = 2;
    exp_q.push_back(e);
  endtask

  task automatic do_save(input logic [XLEN-1:0] base, input bit both, input bit busy_noise, output int lat);
    img_t snap;
    for (int i = 0; i <= NREG; i++) snap[i] = $urandom;
    push_save(base, snap);
    @(posedge clk);
    #1;
    save_req_i    = 1'b1;
    restore_req_i = both;
    base_addr_i   = base;
    ireg_file_i   = snap;
    @(posedge clk);
    #1;
    save_req_i    = 1'b0;
    restore_req_i = 1'b0;
    base_addr_i   = $urandom;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (done_o) break;
      if (lat > 2000) begin
        checks++;
        errors++;
        $display("FAIL save_timeout: got no done_o after %0d cycles expected done_o", lat);
        break;
      end
      @(posedge clk);
      #1;
      // requests and register changes while busy must have no effect
      if (busy_o && busy_noise) begin
        restore_req_i = 1'($urandom_range(0, 1));
        save_req_i    = 1'($urandom_range(0, 1));
        ireg_file_i[$urandom_range(1, NREG)] = $urandom;
      end else begin
        restore_req_i = 1'b0;
        save_req_i    = 1'b0;
      end
    end
    save_req_i    = 1'b0;
    restore_req_i = 1'b0;
  endtask

  task automatic do_restore(input logic [XLEN-1:0] base, output int lat);
    push_restore(base, salt);
    @(posedge clk);
    #1;
    restore_req_i = 1'b1;
    base_addr_i   = base;
    @(posedge clk);
    #1;
    restore_req_i = 1'b0;
    base_addr_i   = $urandom;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (done_o) break;
      if (lat > 3000) begin
        checks++;
        errors++;
        $display("FAIL restore_timeout: got no done_o after %0d cycles expected done_o", lat);
        break;
      end
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int lat;
    int hs0;
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_load_all", {31'b0, load_all_o}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_if.mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_if.mem_we_o}, 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_if.mem_wdata_o, 32'd0);
    chk_img("rst_image", ireg_file_o, '0);
    rst_i = 1'b0;

    // fixed-pattern save, grant tied high
    begin
      img_t snap;
      for (int i = 0; i <= NREG; i++) snap[i] = 32'hA000_0000 + XLEN'(i);
      push_save(32'h0000_1000, snap);
      @(posedge clk);
      #1;
      save_req_i  = 1'b1;
      base_addr_i = 32'h0000_1000;
      ireg_file_i = snap;
      @(posedge clk);
      #1;
      save_req_i = 1'b0;
      lat = 0;
      forever begin
        @(negedge clk);
        lat++;
        if (done_o || lat > 200) break;
      end
      chk("save_latency", lat, 32'd32);
    end

    // stall on idx 5, register file disturbed during the save
    gnt_mode = 2;
    stall_addr = 32'h0000_1010;
    stall_left = 3;
    hold_addr = 32'h0000_1010;
    hold_cnt = 0;
    do_save(32'h0000_1000, 1'b0, 1'b1, lat);
    chk("stall_hold_cycles", hold_cnt, 32'd4);
    chk("stall_save_latency", lat, 32'd35);
    hold_addr = 32'h0000_0003;
    gnt_mode = 0;

    // restore with rdata = ~addr, 2-cycle read latency
    salt = '0;
    rv_delay = 2;
    do_restore(32'h0000_2000, lat);

    // simultaneous save and restore, restore attempts while busy
    hs0 = hs_cnt;
    do_save(32'h0000_3000, 1'b1, 1'b1, lat);
    chk("both_req_save_accesses", hs_cnt - hs0, 32'd31);
    hs0 = hs_cnt;
    repeat (40) @(negedge clk);
    chk("no_transfer_after_ignored", hs_cnt - hs0, 32'd0);
    chk("busy_after_ignored", {31'b0, busy_o}, 32'd0);

    // reset while waiting for read data at idx 10
    push_restore(32'h0000_2000, salt);
    @(posedge clk);
    #1;
    restore_req_i = 1'b1;
    base_addr_i   = 32'h0000_2000;
    @(posedge clk);
    #1;
    restore_req_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (mem_if.mem_req_o && mem_if.mem_gnt_i && mem_if.mem_addr_o == 32'h0000_2024) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_trigger: got no read of 00002024 expected one");
    end
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_busy", {31'b0, busy_o}, 32'd0);
    chk("midrst_done", {31'b0, done_o}, 32'd0);
    chk("midrst_load_all", {31'b0, load_all_o}, 32'd0);
    chk("midrst_mem_req", {31'b0, mem_if.mem_req_o}, 32'd0);
    chk("midrst_mem_addr", mem_if.mem_addr_o, 32'd0);
    chk_img("midrst_image", ireg_file_o, '0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy_o}, 32'd0);
    do_restore(32'h0000_2000, lat);

    // address wrap-around
    do_save(32'hFFFF_FFF8, 1'b0, 1'b0, lat);
    chk("wrap_save_latency", lat, 32'd32);

    // randomized traffic
    gnt_mode = 1;
    rv_delay = 0;
    noise = 1'b1;
    for (int n = 0; n < 8; n++) begin
      logic [XLEN-1:0] b;
      b = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) begin
        do_save(b, 1'($urandom_range(0, 1)), 1'b1, lat);
      end else begin
        salt = $urandom;
        do_restore(b, lat);
      end
    end
    noise = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mgt_01_context_unit.md
MGT_01_CONTEXT_UNIT -- requirements
Module: mgt_01_context_unit

Interface
REQ-001 Parameter: NREG, 31, number of saved integer registers (x1..x31); x0 is never saved.
REQ-002 Parameter: XLEN, 32, data and address width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 save_req_i  in  1  start a context save; sampled only in IDLE.
REQ-007 restore_req_i  in  1  start a context restore; sampled only in IDLE.
REQ-008 base_addr_i  in  XLEN  word-aligned memory base address; sampled with the accepted request.
REQ-009 ireg_file_i  in  XLEN x XLEN  packed snapshot of the register file; entry 0 is ignored.
REQ-010 ireg_file_o  out  XLEN x XLEN  restored register image; entry 0 is constant 0.
REQ-011 load_all_o  out  1  one-cycle strobe commanding the register file to load ireg_file_o.
REQ-012 mem_req_o  out  1  memory request valid.
REQ-013 mem_we_o  out  1  1 = write (save), 0 = read (restore).
REQ-014 mem_addr_o  out  XLEN  request address.
REQ-015 mem_wdata_o  out  XLEN  write data.
REQ-016 mem_gnt_i  in  1  memory accepts the request in the cycle where mem_req_o and mem_gnt_i are both 1.
REQ-017 mem_rvalid_i  in  1  read data valid; arrives 1 or more cycles after the read grant.
REQ-018 mem_rdata_i  in  XLEN  read data.
REQ-019 busy_o  out  1  high in every state except IDLE.
REQ-020 done_o  out  1  one-cycle pulse when a save or restore completes.

Function
REQ-021 FSM states: IDLE, SAVE, LD_REQ, LD_WAIT, COMMIT.
REQ-022 In IDLE, save_req_i=1 SHALL copy ireg_file_i[1..NREG] into an internal buffer, latch base_addr_i, set the index to 1, and enter SAVE on the next cycle.
REQ-023 In IDLE, restore_req_i=1 with save_req_i=0 SHALL latch base_addr_i, set the index to 1, and enter LD_REQ.
REQ-024 When save_req_i and restore_req_i are both 1 in IDLE, save SHALL win and restore SHALL be dropped.
REQ-025 Requests asserted outside IDLE SHALL be ignored and not queued.
REQ-026 In SAVE, the outputs SHALL be: mem_req_o=1, mem_we_o=1, mem_addr_o=base+4*(idx-1), mem_wdata_o=buffer[idx].
REQ-027 Outputs SHALL be held stable until grant; on grant, idx increments.
REQ-028 A grant at idx=NREG SHALL return the FSM to IDLE and pulse done_o in the following cycle.
REQ-029 Later changes on ireg_file_i during SAVE SHALL NOT affect the written data.
REQ-030 In LD_REQ, the outputs SHALL be: mem_req_o=1, mem_we_o=0, mem_addr_o=base+4*(idx-1), mem_wdata_o=0; on grant, the FSM enters LD_WAIT.
REQ-031 In LD_WAIT, mem_req_o SHALL be 0, giving at most one outstanding read.
REQ-032 In LD_WAIT, mem_rvalid_i SHALL write mem_rdata_i into buffer[idx]; then idx increments and the FSM enters LD_REQ, or COMMIT if idx=NREG.
REQ-033 mem_rvalid_i outside LD_WAIT SHALL be ignored.
REQ-034 COMMIT SHALL last exactly 1 cycle, with load_all_o=1 and ireg_file_o equal to the buffer.
REQ-035 After COMMIT the FSM SHALL return to IDLE with done_o=1 for one cycle.
REQ-036 ireg_file_o SHALL always reflect the buffer; entry 0 SHALL always be 0.
REQ-037 Address arithmetic SHALL be modulo 2^XLEN; wrap-around past 0xFFFFFFFC SHALL NOT be flagged.
REQ-038 mem_req_o SHALL never be asserted in IDLE or COMMIT.
REQ-039 Save latency with grant held at 1 SHALL be 1 + NREG cycles from request to done_o.

Reset
REQ-040 rst_i=1 SHALL asynchronously force IDLE, idx=0, buffer=0, base=0.
REQ-041 rst_i=1 SHALL force mem_req_o, mem_we_o, load_all_o, done_o and busy_o to 0, and mem_addr_o and mem_wdata_o to 0.
REQ-042 Reset during any state SHALL abort the transfer without asserting load_all_o or done_o.
REQ-043 After reset deassertion, the block SHALL accept a new request in the first IDLE cycle.

Verification
REQ-044 Save, gnt tied to 1, base=0x1000, ireg_file_i[i]=0xA000_0000+i -> 31 writes to 0x1000..0x1078 with data 0xA000_0001..0xA000_001F, done_o 32 cycles after the request.
REQ-045 Save with gnt low for 3 cycles on idx 5 -> addr 0x1010 and data held for 4 cycles; ireg_file_i changed mid-save does not alter the written data.
REQ-046 Restore, base=0x2000, rvalid 2 cycles after each grant, rdata=~addr -> 31 reads to 0x2000..0x2078, then load_all_o for 1 cycle with ireg_file_o[i]=~(0x2000+4*(i-1)) and ireg_file_o[0]=0, then done_o.
REQ-047 save_req_i and restore_req_i asserted together -> save performed; restore_req_i asserted while busy -> ignored, no further transfer after done_o.
REQ-048 rst_i pulse during LD_WAIT at idx 10 -> immediate IDLE, all outputs 0, no load_all_o; a subsequent restore starts from 0x2000.
REQ-049 base=0xFFFF_FFF8 save -> addresses wrap to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, ... 0x0000_0070.
